// File: rtl/bulls_cows_game.sv
// bulls_cows_game: two-player Bulls and Cows controller with debounced confirm button
module bulls_cows_game #(
  parameter int DEBOUNCE_COUNT = 1000000,
  parameter int RESULT_CYCLES  = 200000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirm_btn,
  input  logic [15:0] SW,
  output logic [2:0]  game_state,
  output logic [2:0]  bull_count,
  output logic [2:0]  cow_count,
  output logic        guess_confirmed,
  output logic [7:0]  J1_points,
  output logic [7:0]  J2_points
);
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam int TW = $clog2(RESULT_CYCLES + 1);

  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } state_t;

  logic          s1_q, s2_q, db_q, db_d, press_q;
  logic [DW-1:0] cnt_q, cnt_d;
  state_t        st_q, st_d;
  logic [15:0]   sec1_q, sec1_d, sec2_q, sec2_d, sec;
  logic [2:0]    b_q, b_d, c_q, c_d, bulls, cows;
  logic          gc_q, gc_d, valid;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    p1_q, p1_d, p2_q, p2_d;
  logic [3:0]    hitv;

  // counter only runs while the synchronized level disagrees with the accepted one
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == DW'(DEBOUNCE_COUNT - 1)) db_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  assign sec = (st_q == J1_GUESS) ? sec2_q : sec1_q;

  // secrets hold distinct digits, so each guess digit hits at most one position
  always_comb begin
    bulls = '0;
    hitv  = '0;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bulls = bulls + {2'b0, SW[4*i+:4] == sec[4*i+:4]};
      valid = valid & (SW[4*i+:4] <= 4'd9);
      for (int j = 0; j < 4; j++) begin
        if (SW[4*i+:4] == sec[4*j+:4]) hitv[i] = 1'b1;
        if (j > i && SW[4*i+:4] == SW[4*j+:4]) valid = 1'b0;
      end
    end
    cows = 3'($countones(hitv)) - bulls;
  end

  always_comb begin
    st_d   = st_q;
    sec1_d = sec1_q;
    sec2_d = sec2_q;
    b_d    = b_q;
    c_d    = c_q;
    gc_d   = gc_q;
    tmr_d  = tmr_q;
    p1_d   = p1_q;
    p2_d   = p2_q;
    if (gc_q) begin
      if (tmr_q == '0) begin
        gc_d = 1'b0;
        st_d = (st_q == J1_GUESS) ? J2_GUESS : J1_GUESS;
      end else tmr_d = tmr_q - 1'b1;
    end else if (press_q) begin
      case (st_q)
        J1_SETUP: if (valid) begin sec1_d = SW; st_d = J2_SETUP; end
        J2_SETUP: if (valid) begin sec2_d = SW; st_d = J1_GUESS; end
        J1_GUESS, J2_GUESS: if (valid) begin
          b_d = bulls;
          c_d = (bulls == 3'd4) ? 3'd0 : cows;
          if (bulls == 3'd4) begin
            st_d = END_GAME;
            if (st_q == J1_GUESS) p1_d = (p1_q == 8'hff) ? p1_q : p1_q + 1'b1;
            else p2_d = (p2_q == 8'hff) ? p2_q : p2_q + 1'b1;
          end else begin
            gc_d  = 1'b1;
            tmr_d = TW'(RESULT_CYCLES - 1);
          end
        end
        END_GAME: begin st_d = J1_SETUP; b_d = '0; c_d = '0; end
        default: st_d = J1_SETUP;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
      st_q    <= J1_SETUP;
      sec1_q  <= '0;
      sec2_q  <= '0;
      b_q     <= '0;
      c_q     <= '0;
      gc_q    <= 1'b0;
      tmr_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      s1_q    <= confirm_btn;
      s2_q    <= s1_q;
      db_q    <= db_d;
      press_q <= db_d & ~db_q;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      sec1_q  <= sec1_d;
      sec2_q  <= sec2_d;
      b_q     <= b_d;
      c_q     <= c_d;
      gc_q    <= gc_d;
      tmr_q   <= tmr_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  assign game_state      = st_q;
  assign bull_count      = b_q;
  assign cow_count       = c_q;
  assign guess_confirmed = gc_q;
  assign J1_points       = p1_q;
  assign J2_points       = p2_q;
endmodule

// File: tb/tb_bulls_cows_game.sv
// tb_bulls_cows_game: randomized game play checked against a transaction-level Bulls and Cows model
module tb_bulls_cows_game;
  localparam int D = 4;
  localparam int R = 16;
  localparam int LAT = 2 + D + 1;

  logic        clock = 1'b0, reset = 1'b1, confirm_btn = 1'b0;
  logic [15:0] SW = '0;
  logic [2:0]  game_state, bull_count, cow_count;
  logic        guess_confirmed;
  logic [7:0]  J1_points, J2_points;

  bulls_cows_game #(.DEBOUNCE_COUNT(D), .RESULT_CYCLES(R)) dut (
    .clock(clock), .reset(reset), .confirm_btn(confirm_btn), .SW(SW),
    .game_state(game_state), .bull_count(bull_count), .cow_count(cow_count),
    .guess_confirmed(guess_confirmed), .J1_points(J1_points), .J2_points(J2_points)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  int m_st, m_b, m_c, m_gc, m_p1, m_p2;
  logic [15:0] m_s1, m_s2;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(game_state), m_st);
    chk({tag, ".bulls"}, int'(bull_count), m_b);
    chk({tag, ".cows"}, int'(cow_count), m_c);
    chk({tag, ".gc"}, int'(guess_confirmed), m_gc);
    chk({tag, ".j1"}, int'(J1_points), m_p1);
    chk({tag, ".j2"}, int'(J2_points), m_p2);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    m_st = 0; m_b = 0; m_c = 0; m_gc = 0; m_p1 = 0; m_p2 = 0; m_s1 = '0; m_s2 = '0;
  endtask

  function automatic int dig(input logic [15:0] x, input int i);
    return int'(x[15-4*i -: 4]);
  endfunction

  function automatic bit is_valid(input logic [15:0] x);
    int seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dig(x, i) > 9) return 1'b0;
      seen |= 1 << dig(x, i);
    end
    return $countones(seen) == 4;
  endfunction

  function automatic logic [15:0] rand_valid();
    int a[10];
    for (int i = 0; i < 10; i++) a[i] = i;
    for (int i = 9; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = a[i];
      a[i] = a[j];
      a[j] = t;
    end
    return {4'(a[0]), 4'(a[1]), 4'(a[2]), 4'(a[3])};
  endfunction

  task automatic apply_press(input logic [15:0] sw, output bit win_open);
    int b = 0, c = 0;
    win_open = 1'b0;
    if (m_st == 7) begin
      m_st = 0; m_b = 0; m_c = 0;
    end else if (is_valid(sw)) begin
      if (m_st == 0) begin m_s1 = sw; m_st = 1; end
      else if (m_st == 1) begin m_s2 = sw; m_st = 2; end
      else begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            if (dig(sw, i) == dig(m_st == 2 ? m_s2 : m_s1, j)) begin
              if (i == j) b++;
              else c++;
            end
        m_b = b;
        m_c = c;
        if (b == 4) begin
          if (m_st == 2) m_p1 = (m_p1 < 255) ? m_p1 + 1 : 255;
          else m_p2 = (m_p2 < 255) ? m_p2 + 1 : 255;
          m_st = 7;
        end else begin
          m_gc = 1;
          win_open = 1'b1;
        end
      end
    end
  endtask

  task automatic do_press(input logic [15:0] sw, input bit mask_press);
    bit w;
    SW = sw;
    confirm_btn = 1'b1;
    repeat (LAT) tick;
    apply_press(sw, w);
    check_all("press");
    confirm_btn = 1'b0;
    repeat (LAT) tick;
    check_all("release");
    if (w) begin
      if (mask_press) confirm_btn = 1'b1;
      repeat (R - 1 - LAT) tick;
      check_all("window");
      tick;
      m_gc = 0;
      m_st = (m_st == 2) ? 3 : 2;
      check_all("expire");
      confirm_btn = 1'b0;
      repeat (LAT) tick;
      check_all("after");
    end
  endtask

  initial begin
    int changes, changed_at;
    logic [2:0] prev;
    bit w;
    logic [15:0] g;
    model_reset();
    repeat (2) tick;
    reset = 1'b0;
    tick;
    check_all("reset");

    do_press(16'h1234, 1'b0);
    do_press(16'h5678, 1'b0);
    do_press(16'h5867, 1'b1);
    chk("score.bulls", int'(bull_count), 1);
    chk("score.cows", int'(cow_count), 3);
    do_press(16'h1234, 1'b0);
    chk("win.j2", int'(J2_points), 1);
    do_press(16'h0000, 1'b0);
    do_press(16'h1123, 1'b0);
    do_press(16'h12A4, 1'b0);

    SW = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      confirm_btn = (k % 2 == 0);
      repeat (2) tick;
    end
    check_all("bounce");
    confirm_btn = 1'b1;
    changes = 0;
    changed_at = -1;
    prev = game_state;
    for (int t = 1; t <= 100; t++) begin
      tick;
      if (game_state != prev) begin
        changes++;
        if (changed_at < 0) changed_at = t;
        prev = game_state;
      end
    end
    apply_press(16'h1234, w);
    chk("hold.once", changes, 1);
    chk("hold.lat", changed_at, LAT);
    check_all("hold");
    confirm_btn = 1'b0;
    repeat (LAT) tick;
    check_all("hold_rel");

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(5, 0))
        0: g = 16'($urandom);
        1: g = (m_st == 2) ? m_s2 : (m_st == 3) ? m_s1 : rand_valid();
        default: g = rand_valid();
      endcase
      do_press(g, 1'($urandom_range(1, 0)));
    end

    while (m_st != 0) do_press(16'h0000, 1'b0);
    for (int n = 0; n < 256; n++) begin
      do_press(16'h9876, 1'b0);
      do_press(16'h0123, 1'b0);
      do_press(16'h0123, 1'b0);
      do_press(16'h0000, 1'b0);
    end
    chk("sat.j1", int'(J1_points), 255);

    do_press(16'h1234, 1'b0);
    do_press(16'h5678, 1'b0);
    SW = 16'h8765;
    confirm_btn = 1'b1;
    repeat (LAT) tick;
    apply_press(16'h8765, w);
    check_all("pre_reset");
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    confirm_btn = 1'b0;
    tick;
    reset = 1'b0;
    repeat (LAT) tick;
    check_all("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
